ast_systolic_ctrl: RTL and testbench

//  Sequencer for the SIZE x SIZE systolic MAC array. Given start and inner dimension k_len, it:
//  - clears the accumulators;
//  - pops the row/col FWFT FIFOs with diagonal skew and drives zero-insert selects on the array inputs;
//  - gates mult_en/acc_en, stalling on FIFO underflow;
//  - signals done when d_out holds the finished product tile.

---
 rtl/ast_sa_pkg.sv | 24 ++
 rtl/ast_skew_window.sv | 22 ++
 rtl/ast_systolic_ctrl.sv | 155 +++++++++++++++
 tb/tb_ast_systolic_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_sa_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Used by ast_systolic_ctrl and ast_skew_window.
package ast_sa_pkg;

  localparam int SA_SIZE    = 4;
  localparam int SA_MAC_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } ast_ctrl_state_t;

  // Feed length: k operands plus skew in and out.
  function automatic int feed_len(
    input int k,
    input int size
  );
    return k + 2 * (size - 1);
  endfunction

endpackage

// File: rtl/ast_skew_window.sv
// Diagonal skew window for one lane index.
// Lane is active while lane <= t < lane + k_q.
module ast_skew_window
  import ast_sa_pkg::*;
#(
  parameter int KW = 8
) (
  input  logic [KW:0]   t,
  input  logic [KW-1:0] k_q,
  input  logic [KW:0]   lane,
  output logic          in_win
);

  logic [KW+1:0] hi;

  // Window compare, widened so lane + k_q never wraps.
  always_comb begin
    hi     = {1'b0, lane} + {2'b00, k_q};
    in_win = (t >= lane) && ({1'b0, t} < hi);
  end

endmodule

// File: rtl/ast_systolic_ctrl.sv
// Sequencer for a SIZE x SIZE systolic MAC array.
// Optional perf counters under AST_CTRL_PERF_EN.
module ast_systolic_ctrl
  import ast_sa_pkg::*;
#(
  parameter int SIZE    = SA_SIZE,
  parameter int KW      = 8,
  parameter int MAC_LAT = SA_MAC_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic [SIZE-1:0] row_empty,
  input  logic [SIZE-1:0] col_empty,
  output logic [SIZE-1:0] row_rd_en,
  output logic [SIZE-1:0] col_rd_en,
  output logic [SIZE-1:0] a_zero,
  output logic [SIZE-1:0] b_zero,
  output logic            load_en,
  output logic            mult_en,
  output logic            acc_en,
  output logic            busy,
  output logic            done
`ifdef AST_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_busy_cyc,
  output logic [31:0]     perf_stall_cyc
`endif
);

  localparam int TW = KW + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  ast_ctrl_state_t state;
  ast_ctrl_state_t nxt;

  logic [KW-1:0]   k_q;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_nxt;
  logic [TW-1:0]   t_last;
  logic [DW-1:0]   dcnt;
  logic [DW-1:0]   d_nxt;
  logic [SIZE-1:0] win;
  logic            stall;

  // Row i and column i share one window instance.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    ast_skew_window #(
      .KW(KW)
    ) u_win (
      .t     (t),
      .k_q   (k_q),
      .lane  (TW'(i)),
      .in_win(win[i])
    );
  end

  // Last feed step and underflow stall detection.
  always_comb begin
    t_last = TW'(feed_len(int'(k_q), SIZE) - 1);
    stall  = (state == FEED) &&
             (|(win & (row_empty | col_empty)));
  end

  // Next state and array control outputs.
  always_comb begin
    nxt       = state;
    t_nxt     = t;
    d_nxt     = dcnt;
    row_rd_en = '0;
    col_rd_en = '0;
    a_zero    = '1;
    b_zero    = '1;
    load_en   = 1'b0;
    mult_en   = 1'b0;
    acc_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        load_en = 1'b1;
        t_nxt   = '0;
        nxt     = (k_q == '0) ? DONE : FEED;
      end
      FEED: begin
        busy   = 1'b1;
        a_zero = ~win;
        b_zero = ~win;
        if (!stall) begin
          row_rd_en = win;
          col_rd_en = win;
          mult_en   = 1'b1;
          acc_en    = 1'b1;
          if (t == t_last) begin
            nxt   = DRAIN;
            d_nxt = '0;
          end else begin
            t_nxt = t + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        mult_en = 1'b1;
        acc_en  = 1'b1;
        if (dcnt == DW'(MAC_LAT - 1)) nxt = DONE;
        else d_nxt = dcnt + 1'b1;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, feed step and drain counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k_q   <= '0;
      t     <= '0;
      dcnt  <= '0;
    end else begin
      state <= nxt;
      t     <= t_nxt;
      dcnt  <= d_nxt;
      if (state == IDLE && start) k_q <= k_len;
    end
  end

`ifdef AST_CTRL_PERF_EN
  // Saturating busy/stall counters, cleared per job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (state == IDLE && start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && !(&perf_busy_cyc))
        perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if (stall && !(&perf_stall_cyc))
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ast_systolic_ctrl.sv
// Bench for ast_systolic_ctrl with a FIFO and MAC array model.
// Perf counters checked when AST_CTRL_PERF_EN is defined.
module tb_ast_systolic_ctrl;
  import ast_sa_pkg::*;

  localparam int SIZE    = 4;
  localparam int KW      = 8;
  localparam int MAC_LAT = 1;
  localparam int KMAX    = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [SIZE-1:0] row_empty;
  logic [SIZE-1:0] col_empty;
  logic [SIZE-1:0] row_rd_en;
  logic [SIZE-1:0] col_rd_en;
  logic [SIZE-1:0] a_zero;
  logic [SIZE-1:0] b_zero;
  logic            load_en;
  logic            mult_en;
  logic            acc_en;
  logic            busy;
  logic            done;
`ifdef AST_CTRL_PERF_EN
  logic [31:0]     perf_busy_cyc;
  logic [31:0]     perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  ast_systolic_ctrl #(
    .SIZE   (SIZE),
    .KW     (KW),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k_len    (k_len),
    .row_empty(row_empty),
    .col_empty(col_empty),
    .row_rd_en(row_rd_en),
    .col_rd_en(col_rd_en),
    .a_zero   (a_zero),
    .b_zero   (b_zero),
    .load_en  (load_en),
    .mult_en  (mult_en),
    .acc_en   (acc_en),
    .busy     (busy),
    .done     (done)
`ifdef AST_CTRL_PERF_EN
    ,
    .perf_busy_cyc (perf_busy_cyc),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  typedef struct {
    int            k;
    logic [SIZE-1:0] rmask;
    logic [SIZE-1:0] cmask;
    int            e_from;
    int            e_to;
    int            lat;
    int            stalls;
    bit            frz;
    bit            hold;
    int            abort_at;
  } vec_t;

  typedef struct packed {
    int                         lat;
    int                         stalls;
    int                         k;
    logic [SIZE*SIZE-1:0][31:0] c;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vt[8];

  int rq[SIZE][$];
  int cq[SIZE][$];
  int ar[SIZE][SIZE];
  int br[SIZE][SIZE];
  int acc[SIZE][SIZE];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},
        {busy, done, load_en, mult_en, acc_en,
         row_rd_en, col_rd_en}, 0);
    chk({tag, "_zero"}, {a_zero, b_zero}, 8'hFF);
  endtask

  function automatic vec_t mk(
    input int k, input logic [SIZE-1:0] rm,
    input logic [SIZE-1:0] cm, input int ef, input int et,
    input int lat, input int st, input bit frz,
    input bit hold, input int ab);
    vec_t v;
    v.k = k; v.rmask = rm; v.cmask = cm;
    v.e_from = ef; v.e_to = et; v.lat = lat;
    v.stalls = st; v.frz = frz; v.hold = hold;
    v.abort_at = ab;
    return v;
  endfunction

  task automatic run_job(input vec_t v);
    int   amat[SIZE][KMAX];
    int   bmat[KMAX][SIZE];
    int   nar[SIZE][SIZE];
    int   nbr[SIZE][SIZE];
    int   ain[SIZE];
    int   bin[SIZE];
    int   pr[SIZE];
    int   pc[SIZE];
    exp_t e;
    int   s, al, bt, uf, obs_st, done_c, nbad;
    bit   seen, forced, aborted;
    logic [SIZE-1:0] prev_az;
    for (int i = 0; i < SIZE; i++) begin
      rq[i].delete();
      cq[i].delete();
      pr[i] = 0;
      pc[i] = 0;
      for (int kk = 0; kk < v.k; kk++) begin
        amat[i][kk] = $urandom_range(0, 255);
        bmat[kk][i] = $urandom_range(0, 255);
        rq[i].push_back(amat[i][kk]);
        cq[i].push_back(bmat[kk][i]);
      end
    end
    e.lat = v.lat;
    e.stalls = v.stalls;
    e.k = v.k;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        s = 0;
        for (int kk = 0; kk < v.k; kk++)
          s += amat[i][kk] * bmat[kk][j];
        e.c[i*SIZE+j] = s;
      end
    sb.push_back(e);
    uf = 0; obs_st = 0; done_c = 0;
    seen = 0; aborted = 0; prev_az = '1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      start  = (c == 0) || (v.hold && !seen);
      k_len  = (c == 0) ? KW'(v.k) : 8'hAA;
      forced = (c >= v.e_from) && (c <= v.e_to);
      for (int i = 0; i < SIZE; i++) begin
        row_empty[i] = (rq[i].size() == 0) ||
                       (forced && v.rmask[i]);
        col_empty[i] = (cq[i].size() == 0) ||
                       (forced && v.cmask[i]);
      end
      #1;
      if (c == v.abort_at) begin
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          chk("abort_idle", {busy, done}, 0);
        end
        aborted = 1;
        break;
      end
      if (busy && !load_en && !mult_en) obs_st++;
      if (v.frz && forced) begin
        chk("frozen",
            {mult_en, acc_en, row_rd_en, col_rd_en}, 0);
        if (c > v.e_from)
          chk("frozen_zero", {a_zero, b_zero},
              {prev_az, prev_az});
      end
      if (seen && c > done_c) begin
        chk("idle_after", {busy, done}, 0);
`ifdef AST_CTRL_PERF_EN
        chk("perf_hold", perf_busy_cyc, e.lat - 1);
`endif
      end
      if (done && !seen) begin
        seen = 1;
        done_c = c;
        e = sb.pop_front();
        chk("latency", c, e.lat);
        chk("stalls", obs_st, e.stalls);
        chk("underflow", uf, 0);
        nbad = 0;
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++)
            if (acc[i][j] != int'(e.c[i*SIZE+j])) begin
              if (nbad == 0)
                $display("FAIL product[%0d][%0d]: got %0d expected %0d",
                         i, j, acc[i][j], e.c[i*SIZE+j]);
              nbad++;
            end
        chk("product_bad_cells", nbad, 0);
        for (int i = 0; i < SIZE; i++) begin
          chk($sformatf("pops_row%0d", i), pr[i], e.k);
          chk($sformatf("pops_col%0d", i), pc[i], e.k);
        end
`ifdef AST_CTRL_PERF_EN
        chk("perf_busy", perf_busy_cyc, e.lat - 1);
        chk("perf_stall", perf_stall_cyc, e.stalls);
`endif
      end
      if (load_en) begin
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++) begin
            acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
          end
      end else if (mult_en) begin
        for (int i = 0; i < SIZE; i++) begin
          ain[i] = 0;
          bin[i] = 0;
          if (!a_zero[i] && rq[i].size() > 0) ain[i] = rq[i][0];
          if (!b_zero[i] && cq[i].size() > 0) bin[i] = cq[i][0];
        end
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++) begin
            al = (j == 0) ? ain[i] : ar[i][j-1];
            bt = (i == 0) ? bin[j] : br[i-1][j];
            acc[i][j] += al * bt;
            nar[i][j] = al;
            nbr[i][j] = bt;
          end
        ar = nar;
        br = nbr;
      end
      for (int i = 0; i < SIZE; i++) begin
        if (row_rd_en[i]) begin
          pr[i]++;
          if (rq[i].size() == 0) uf++;
          else void'(rq[i].pop_front());
        end
        if (col_rd_en[i]) begin
          pc[i]++;
          if (cq[i].size() == 0) uf++;
          else void'(cq[i].pop_front());
        end
      end
      prev_az = a_zero;
      if (seen && c >= done_c + 3) break;
    end
    start = 1'b0;
    if (!seen && !aborted) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done for k=%0d expected at %0d",
               v.k, v.lat);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    vt[0] = mk(3, 4'b0000, 4'b0000, -1, -1, 12, 0, 0, 0, -1);
    vt[1] = mk(0, 4'b0000, 4'b0000, -1, -1,  2, 0, 0, 0, -1);
    vt[2] = mk(5, 4'b0100, 4'b0000,  6,  8, 17, 3, 1, 0, -1);
    vt[3] = mk(5, 4'b0000, 4'b1000,  0,  4, 14, 0, 0, 0, -1);
    vt[4] = mk(5, 4'b0000, 4'b0000, -1, -1, 14, 0, 0, 0,  5);
    vt[5] = mk(1, 4'b0000, 4'b0000, -1, -1, 10, 0, 0, 0, -1);
    vt[6] = mk(4, 4'b0000, 4'b0000, -1, -1, 13, 0, 0, 1, -1);
    vt[7] = mk(8, 4'b0001, 4'b0010,  3,  3, 18, 1, 1, 0, -1);

    reset     = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    row_empty = '0;
    col_empty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
`ifdef AST_CTRL_PERF_EN
    chk("reset_perf", {perf_busy_cyc, perf_stall_cyc}, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {busy, done, load_en}, 0);

    for (int n = 0; n < 8; n++) run_job(vt[n]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
